n101_tl_repeater_cnt: RTL and testbench
=======================================

// Module: n101_tl_repeater_cnt
// PURPOSE
// - Counted TileLink A-channel repeater: replays one accepted request COUNT+1 times on deq without enq re-handshake.
// - Parametrised successor of the single-flag repeater: widths, replay count, beat index/last outputs, abort.
// - Sits between the TL fragmenter/width-adapter and a narrow peripheral port; the fragmenter supplies per-request COUNT.
// PARAMETERS
// - AW         30  address width
// - DW         32  data width; mask width = DW/8
// - SRCW       2   source id width
// - CW         4   replay count / beat index width; max beats per request = 2^CW
// - ADDR_STEP  4   address increment per beat (only with N101_TL_RPT_ADDR_INC_EN)
// PORTS
// - clock              in   1       clock
// - reset              in   1       async reset, active-high
// - io_abort           in   1       sync: drop remaining replays
// - io_full            out  1       replay in progress (saved request held)
// - io_enq_ready       out  1       enq handshake ready
// - io_enq_valid       in   1       enq handshake valid
// - io_enq_bits_opcode/param/size  in  3 each  TL A fields
// - io_enq_bits_source  in  SRCW    TL source
// - io_enq_bits_address in  AW      TL address
// - io_enq_bits_mask    in  DW/8    TL mask
// - io_enq_bits_data    in  DW      TL data
// - io_enq_count        in  CW      extra replays after first beat (0 = plain pass-through)
// - io_deq_ready       in   1       deq handshake ready
// - io_deq_valid       out  1       deq handshake valid
// - io_deq_bits_*      out  as enq  TL A fields to downstream
// - io_deq_beat        out  CW      beat index of current deq beat (0 = first)
// - io_deq_last        out  1       current deq beat is final of the request
// BEHAVIOUR
// - Regs: full, rem[CW-1:0] (beats left incl. current), beat[CW-1:0], saved_* (all TL fields).
// - Reset: full=0, rem=0, beat=0, saved_*=0 -> io_full=0, io_deq_beat=0; io_enq_ready=io_deq_ready,
//   io_deq_valid=io_enq_valid, io_deq_last=(io_enq_count==0), deq bits = enq bits (idle pass-through).
// - IDLE (full=0): deq_valid=enq_valid; deq_bits=enq_bits comb, 0-cycle latency; enq_ready=deq_ready; beat=0.
//   * enq fire with count==0: single beat, deq_last=1, no state change.
//   * enq fire with count!=0: full<=1, saved_*<=enq bits, rem<=count, beat<=1. Comb first beat deq_last=0.
// - REPLAY (full=1): enq_ready=0; deq_valid=1; deq_bits=saved_*; deq_beat=beat; deq_last=(rem==1).
//   * deq fire, rem!=1: rem<=rem-1, beat<=beat+1.
//   * deq fire, rem==1: full<=0, rem<=0, beat<=0 (next cycle IDLE, new enq may pass same cycle).
//   * no deq fire: all state and deq bits held stable (TL valid/bits stability).
// - io_abort: while full, full<=0, rem<=0, beat<=0 next edge; wins over simultaneous deq fire
//   (the firing beat is still delivered downstream; no further beats). Ignored while idle.
// - count=2^CW-1 gives 2^CW beats; beat reaches 2^CW-1 on last, never wraps within a request.
// - Address arithmetic modulo 2^AW (silent wrap). saved_* written only on capture.
// - Async reset mid-replay: immediate return to IDLE; replay lost, no deq beat generated.
// CONFIGURATION
// - N101_TL_RPT_ADDR_INC_EN defined: deq address = base + beat*ADDR_STEP (mod 2^AW); base = enq addr
//   in IDLE, saved_address in REPLAY. Implemented with a registered running address, no multiplier.
// - Undefined: deq address = base for every beat (identical replay); ADDR_STEP unused.
// TESTING
// - count=0, addr=0x100, deq_ready=1 -> one deq beat same cycle, last=1, beat=0, full stays 0.
// - count=3, data=0xDEADBEEF, deq_ready=1 -> 4 beats beat=0..3, last only on beat 3, enq_ready=0 cycles 2-4.
// - count=2, deq_ready toggled 1,0,0,1,1 -> bits/beat held during stalls, 3 beats total, full drops after 3rd fire.
// - count=5, abort asserted with 2nd beat fire -> exactly 2 beats out, full=0 next cycle, next enq passes through.
// - ADDR_INC_EN, ADDR_STEP=4, addr=0x3FFFFFFC, count=1 -> addresses 0x3FFFFFFC, 0x00000000 (wrap).
// - reset asserted mid-replay (count=7, after beat 2) -> full=0, beat=0 immediately; no further deq beats.

Source files
------------

// File: rtl/n101_tl_repeater_cnt_if.sv
// TileLink A-channel handshake bundle: valid/ready plus the A-channel fields.
// Latency: none (wires only).
// Backpressure: master drives valid and fields, slave drives ready.
// Ports (modports):
//   master - drives valid, opcode, param, size, source, address, mask, data; receives ready
//   slave  - receives valid and fields; drives ready
interface n101_tl_repeater_cnt_if #(
    parameter int AW   = 30,
    parameter int DW   = 32,
    parameter int SRCW = 2
);
    logic            valid;
    logic            ready;
    logic [2:0]      opcode;
    logic [2:0]      param;
    logic [2:0]      size;
    logic [SRCW-1:0] source;
    logic [AW-1:0]   address;
    logic [DW/8-1:0] mask;
    logic [DW-1:0]   data;

    modport master (
        output valid, opcode, param, size, source, address, mask, data,
        input  ready
    );

    modport slave (
        input  valid, opcode, param, size, source, address, mask, data,
        output ready
    );
endinterface

// File: rtl/n101_tl_repeater_cnt.sv
// Counted TL A-channel repeater: one accepted request is replayed count+1 times on deq.
// Latency: first beat passes through combinationally (0 cycles); replays follow one per deq fire.
// Backpressure: enq_ready follows deq_ready while idle and is held low for the whole replay.
// Ports:
//   clock, reset (async, active-high)
//   io_abort     - drop remaining replays (ignored while idle)
//   io_full      - a saved request is being replayed
//   io_enq       - upstream A channel (slave), io_enq_count = extra beats after the first
//   io_deq       - downstream A channel (master), io_deq_beat = beat index, io_deq_last = final beat
// Build option: define N101_TL_RPT_ADDR_INC_EN to step the deq address by ADDR_STEP per beat.
// The interface instances must be built with the same AW/DW/SRCW as this module.
module n101_tl_repeater_cnt #(
    parameter int AW        = 30,
    parameter int DW        = 32,
    parameter int SRCW      = 2,
    parameter int CW        = 4,
    parameter int ADDR_STEP = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   io_abort,
    output logic                   io_full,
    n101_tl_repeater_cnt_if.slave  io_enq,
    input  logic [CW-1:0]          io_enq_count,
    n101_tl_repeater_cnt_if.master io_deq,
    output logic [CW-1:0]          io_deq_beat,
    output logic                   io_deq_last
);

    typedef enum logic {
        IDLE   = 1'b0,
        REPLAY = 1'b1
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   rem, rem_nxt;     // beats left, including the one currently offered
    logic [CW-1:0]   beat, beat_nxt;
    logic            capture;
    logic            advance;

    logic [2:0]      saved_opcode;
    logic [2:0]      saved_param;
    logic [2:0]      saved_size;
    logic [SRCW-1:0] saved_source;
    logic [AW-1:0]   saved_address;
    logic [DW/8-1:0] saved_mask;
    logic [DW-1:0]   saved_data;

`ifdef N101_TL_RPT_ADDR_INC_EN
    // Running address of the beat currently offered in REPLAY; an adder
    // per beat replaces base + beat*ADDR_STEP.
    localparam logic [AW-1:0] STEP = AW'(ADDR_STEP);
    logic [AW-1:0]   run_addr;
`endif

    assign io_full = (state == REPLAY);

    always_comb begin
        state_nxt      = state;
        rem_nxt        = rem;
        beat_nxt       = beat;
        capture        = 1'b0;
        advance        = 1'b0;
        // Idle pass-through by default.
        io_enq.ready   = io_deq.ready;
        io_deq.valid   = io_enq.valid;
        io_deq.opcode  = io_enq.opcode;
        io_deq.param   = io_enq.param;
        io_deq.size    = io_enq.size;
        io_deq.source  = io_enq.source;
        io_deq.address = io_enq.address;
        io_deq.mask    = io_enq.mask;
        io_deq.data    = io_enq.data;
        io_deq_beat    = '0;
        io_deq_last    = (io_enq_count == '0);

        case (state)
            IDLE: begin
                // First beat goes out combinationally; only multi-beat requests are saved.
                if (io_enq.valid && io_deq.ready && (io_enq_count != '0)) begin
                    capture   = 1'b1;
                    state_nxt = REPLAY;
                    rem_nxt   = io_enq_count;
                    beat_nxt  = CW'(1);
                end
            end
            REPLAY: begin
                io_enq.ready   = 1'b0;
                io_deq.valid   = 1'b1;
                io_deq.opcode  = saved_opcode;
                io_deq.param   = saved_param;
                io_deq.size    = saved_size;
                io_deq.source  = saved_source;
`ifdef N101_TL_RPT_ADDR_INC_EN
                io_deq.address = run_addr;
`else
                io_deq.address = saved_address;
`endif
                io_deq.mask    = saved_mask;
                io_deq.data    = saved_data;
                io_deq_beat    = beat;
                io_deq_last    = (rem == CW'(1));

                // Abort beats a simultaneous fire: that beat is delivered, nothing after it.
                if (io_abort) begin
                    state_nxt = IDLE;
                    rem_nxt   = '0;
                    beat_nxt  = '0;
                end else if (io_deq.ready) begin
                    if (rem == CW'(1)) begin
                        state_nxt = IDLE;
                        rem_nxt   = '0;
                        beat_nxt  = '0;
                    end else begin
                        rem_nxt   = rem - CW'(1);
                        beat_nxt  = beat + CW'(1);
                        advance   = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            rem           <= '0;
            beat          <= '0;
            saved_opcode  <= '0;
            saved_param   <= '0;
            saved_size    <= '0;
            saved_source  <= '0;
            saved_address <= '0;
            saved_mask    <= '0;
            saved_data    <= '0;
`ifdef N101_TL_RPT_ADDR_INC_EN
            run_addr      <= '0;
`endif
        end else begin
            state <= state_nxt;
            rem   <= rem_nxt;
            beat  <= beat_nxt;
            if (capture) begin
                saved_opcode  <= io_enq.opcode;
                saved_param   <= io_enq.param;
                saved_size    <= io_enq.size;
                saved_source  <= io_enq.source;
                saved_address <= io_enq.address;
                saved_mask    <= io_enq.mask;
                saved_data    <= io_enq.data;
            end
`ifdef N101_TL_RPT_ADDR_INC_EN
            // Beat 0 went out at the enq address, so the first replay starts one step on.
            if (capture) begin
                run_addr <= io_enq.address + STEP;
            end else if (advance) begin
                run_addr <= run_addr + STEP;
            end
`endif
        end
    end

endmodule

// File: tb/tb_n101_tl_repeater_cnt.sv
// Bench for n101_tl_repeater_cnt: idle pass-through vector table plus multi-cycle
// sequences for replay, stalls, abort, max count, address stepping and reset mid-replay.
// Inputs change 1 time unit after the rising edge; outputs are sampled before the next edge.
module tb_n101_tl_repeater_cnt;
    localparam int AW   = 30;
    localparam int DW   = 32;
    localparam int SRCW = 2;
    localparam int CW   = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          io_abort;
    logic          io_full;
    logic [CW-1:0] io_enq_count;
    logic [CW-1:0] io_deq_beat;
    logic          io_deq_last;

    n101_tl_repeater_cnt_if #(.AW(AW), .DW(DW), .SRCW(SRCW)) enq_if ();
    n101_tl_repeater_cnt_if #(.AW(AW), .DW(DW), .SRCW(SRCW)) deq_if ();

    n101_tl_repeater_cnt #(.AW(AW), .DW(DW), .SRCW(SRCW), .CW(CW), .ADDR_STEP(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .io_abort     (io_abort),
        .io_full      (io_full),
        .io_enq       (enq_if),
        .io_enq_count (io_enq_count),
        .io_deq       (deq_if),
        .io_deq_beat  (io_deq_beat),
        .io_deq_last  (io_deq_last)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic vld, input logic [CW-1:0] cnt,
                         input logic [AW-1:0] addr, input logic [DW-1:0] data);
        enq_if.valid   = vld;
        enq_if.opcode  = 3'd4;
        enq_if.param   = 3'd0;
        enq_if.size    = 3'd2;
        enq_if.source  = 2'd1;
        enq_if.address = addr;
        enq_if.mask    = 4'hF;
        enq_if.data    = data;
        io_enq_count   = cnt;
    endtask

    // Expected deq address of beat b for a request based at base.
    function automatic logic [AW-1:0] exp_addr(input logic [AW-1:0] base, input int b);
`ifdef N101_TL_RPT_ADDR_INC_EN
        logic [AW-1:0] off;
        off = AW'(b * 4);
        return base + off;
`else
        return base + AW'(b * 0);
`endif
    endfunction

    typedef struct {
        logic          vld;
        logic          rdy;
        logic [CW-1:0] cnt;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          e_vld;
        logic          e_rdy;
        logic          e_last;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int fires;
        int exp_beat;
        logic rdy_seq[5];

        vecs[0] = '{1'b1, 1'b1, 4'd0,  30'h100,  32'h11111111, 1'b1, 1'b1, 1'b1};
        vecs[1] = '{1'b0, 1'b1, 4'd0,  30'h104,  32'h22222222, 1'b0, 1'b1, 1'b1};
        vecs[2] = '{1'b1, 1'b0, 4'd3,  30'h108,  32'h33333333, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 4'd3,  30'h10C,  32'h44444444, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 4'd15, 30'h110,  32'h55555555, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 4'd0,  30'h114,  32'h66666666, 1'b0, 1'b0, 1'b1};

        // ---------------- reset state ----------------
        reset = 1'b1;
        io_abort = 1'b0;
        deq_if.ready = 1'b1;
        drive(1'b1, 4'd0, 30'h0, 32'h0);
        #2;
        chk("rst_full", io_full, 0);
        chk("rst_beat", io_deq_beat, 0);
        chk("rst_deq_valid", deq_if.valid, 1);
        chk("rst_enq_ready", enq_if.ready, 1);
        chk("rst_last", io_deq_last, 1);
        deq_if.ready = 1'b0;
        io_enq_count = 4'd3;
        #1;
        chk("rst_enq_ready_low", enq_if.ready, 0);
        chk("rst_last_cnt3", io_deq_last, 0);
        tick();
        reset = 1'b0;
        drive(1'b0, 4'd0, 30'h0, 32'h0);
        tick();

        // ---------------- idle pass-through table ----------------
        for (int i = 0; i < 6; i++) begin
            deq_if.ready = vecs[i].rdy;
            drive(vecs[i].vld, vecs[i].cnt, vecs[i].addr, vecs[i].data);
            #1;
            chk($sformatf("vec%0d_valid", i), deq_if.valid, vecs[i].e_vld);
            chk($sformatf("vec%0d_ready", i), enq_if.ready, vecs[i].e_rdy);
            chk($sformatf("vec%0d_last", i), io_deq_last, vecs[i].e_last);
            chk($sformatf("vec%0d_addr", i), deq_if.address, vecs[i].addr);
            chk($sformatf("vec%0d_data", i), deq_if.data, vecs[i].data);
            chk($sformatf("vec%0d_beat", i), io_deq_beat, 0);
            tick();
            chk($sformatf("vec%0d_full", i), io_full, 0);
        end

        // ---------------- count=0 single beat ----------------
        deq_if.ready = 1'b1;
        drive(1'b1, 4'd0, 30'h100, 32'h12345678);
        #1;
        chk("c0_valid", deq_if.valid, 1);
        chk("c0_addr", deq_if.address, 30'h100);
        chk("c0_last", io_deq_last, 1);
        chk("c0_beat", io_deq_beat, 0);
        tick();
        chk("c0_full", io_full, 0);
        drive(1'b0, 4'd0, 30'h0, 32'h0);

        // ---------------- count=3, four beats ----------------
        drive(1'b1, 4'd3, 30'h40, 32'hDEADBEEF);
        #1;
        chk("c3_b0_valid", deq_if.valid, 1);
        chk("c3_b0_enq_ready", enq_if.ready, 1);
        chk("c3_b0_last", io_deq_last, 0);
        chk("c3_b0_data", deq_if.data, 32'hDEADBEEF);
        tick();
        drive(1'b1, 4'd0, 30'h999, 32'h0BADF00D);   // must not disturb the replay
        for (int b = 1; b <= 3; b++) begin
            #1;
            chk($sformatf("c3_b%0d_full", b), io_full, 1);
            chk($sformatf("c3_b%0d_enq_ready", b), enq_if.ready, 0);
            chk($sformatf("c3_b%0d_valid", b), deq_if.valid, 1);
            chk($sformatf("c3_b%0d_data", b), deq_if.data, 32'hDEADBEEF);
            chk($sformatf("c3_b%0d_src", b), deq_if.source, 2'd1);
            chk($sformatf("c3_b%0d_beat", b), io_deq_beat, b);
            chk($sformatf("c3_b%0d_last", b), io_deq_last, (b == 3));
            chk($sformatf("c3_b%0d_addr", b), deq_if.address, exp_addr(30'h40, b));
            tick();
        end
        chk("c3_full_end", io_full, 0);
        drive(1'b0, 4'd0, 30'h0, 32'h0);
        #1;
        chk("c3_idle_valid", deq_if.valid, 0);

        // ---------------- count=2 with stalls ----------------
        rdy_seq = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        fires = 0;
        exp_beat = 0;
        for (int i = 0; i < 5; i++) begin
            deq_if.ready = rdy_seq[i];
            if (i == 0) drive(1'b1, 4'd2, 30'h80, 32'hCAFEF00D);
            else        drive(1'b0, 4'd0, 30'h7F0, 32'h0);
            #1;
            chk($sformatf("stall%0d_valid", i), deq_if.valid, 1);
            chk($sformatf("stall%0d_beat", i), io_deq_beat, exp_beat);
            chk($sformatf("stall%0d_data", i), deq_if.data, 32'hCAFEF00D);
            chk($sformatf("stall%0d_addr", i), deq_if.address, exp_addr(30'h80, exp_beat));
            chk($sformatf("stall%0d_last", i), io_deq_last, (exp_beat == 2));
            if (deq_if.valid && deq_if.ready) begin
                fires++;
                exp_beat++;
            end
            tick();
        end
        chk("stall_fires", fires, 3);
        chk("stall_full_end", io_full, 0);

        // ---------------- abort with second beat ----------------
        fires = 0;
        deq_if.ready = 1'b1;
        drive(1'b1, 4'd5, 30'h300, 32'hA5A5A5A5);
        #1;
        if (deq_if.valid && deq_if.ready) fires++;
        tick();
        drive(1'b0, 4'd0, 30'h0, 32'h0);
        io_abort = 1'b1;
        #1;
        chk("abort_b1_beat", io_deq_beat, 1);
        chk("abort_b1_valid", deq_if.valid, 1);
        if (deq_if.valid && deq_if.ready) fires++;
        tick();
        io_abort = 1'b0;
        #1;
        chk("abort_full", io_full, 0);
        chk("abort_beat", io_deq_beat, 0);
        chk("abort_no_more_valid", deq_if.valid, 0);
        chk("abort_fires", fires, 2);
        drive(1'b1, 4'd0, 30'h200, 32'h00000055);
        #1;
        chk("abort_next_valid", deq_if.valid, 1);
        chk("abort_next_addr", deq_if.address, 30'h200);
        chk("abort_next_last", io_deq_last, 1);
        chk("abort_next_enq_ready", enq_if.ready, 1);
        tick();
        chk("abort_next_full", io_full, 0);

        // ---------------- abort while idle is ignored ----------------
        io_abort = 1'b1;
        drive(1'b1, 4'd2, 30'h400, 32'h77777777);
        #1;
        tick();
        io_abort = 1'b0;
        drive(1'b0, 4'd0, 30'h0, 32'h0);
        #1;
        chk("idle_abort_full", io_full, 1);
        chk("idle_abort_beat", io_deq_beat, 1);
        tick();
        tick();
        chk("idle_abort_done", io_full, 0);

        // ---------------- address at top of space, count=1 ----------------
        drive(1'b1, 4'd1, 30'h3FFFFFFC, 32'h88888888);
        #1;
        chk("wrap_b0_addr", deq_if.address, 30'h3FFFFFFC);
        tick();
        drive(1'b0, 4'd0, 30'h0, 32'h0);
        #1;
`ifdef N101_TL_RPT_ADDR_INC_EN
        chk("wrap_b1_addr", deq_if.address, 30'h00000000);
`else
        chk("wrap_b1_addr", deq_if.address, 30'h3FFFFFFC);
`endif
        chk("wrap_b1_last", io_deq_last, 1);
        tick();
        chk("wrap_full_end", io_full, 0);

        // ---------------- maximum count: 16 beats ----------------
        drive(1'b1, 4'd15, 30'h1000, 32'h99999999);
        #1;
        chk("max_b0_last", io_deq_last, 0);
        tick();
        drive(1'b0, 4'd0, 30'h0, 32'h0);
        for (int b = 1; b <= 15; b++) begin
            #1;
            chk($sformatf("max_b%0d_beat", b), io_deq_beat, b);
            chk($sformatf("max_b%0d_last", b), io_deq_last, (b == 15));
            chk($sformatf("max_b%0d_addr", b), deq_if.address, exp_addr(30'h1000, b));
            tick();
        end
        chk("max_full_end", io_full, 0);
        chk("max_beat_end", io_deq_beat, 0);

        // ---------------- reset mid-replay ----------------
        drive(1'b1, 4'd7, 30'h2000, 32'hBBBBBBBB);
        #1;
        tick();
        drive(1'b0, 4'd0, 30'h0, 32'h0);
        tick();
        tick();
        #1;
        chk("rstmid_beat_before", io_deq_beat, 3);
        chk("rstmid_full_before", io_full, 1);
        reset = 1'b1;
        #1;
        chk("rstmid_full", io_full, 0);
        chk("rstmid_beat", io_deq_beat, 0);
        chk("rstmid_valid", deq_if.valid, 0);
        fires = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) reset = 1'b0;
            tick();
            if (deq_if.valid) fires++;
        end
        chk("rstmid_no_beats", fires, 0);
        chk("rstmid_full_after", io_full, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
